// File: rtl/cpu_core_mc.sv
`timescale 1ns/1ps
// cpu_core_mc: multi-cycle accumulator CPU with one req/ready memory port shared by fetch and LD/ST.
// Define CPU_RETIRE_CNT_EN to build the saturating retired-instruction counter on retire_cnt.
module cpu_core_mc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic [15:0]           retire_cnt
);

    localparam int unsigned RbW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpMova = 4'h7;
    localparam logic [3:0] OpMovb = 4'h8;
    localparam logic [3:0] OpLd   = 4'h9;
    localparam logic [3:0] OpSt   = 4'hA;
    localparam logic [3:0] OpBeqz = 4'hB;
    localparam logic [3:0] OpBnez = 4'hC;
    localparam logic [3:0] OpJmp  = 4'hD;
    localparam logic [3:0] OpShli = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]            ir_q, ir_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  reg_we;

    logic [3:0]            op;
    logic [3:0]            f;
    logic [RbW-1:0]        rb;
    logic [DATA_WIDTH-1:0] rb_val;
    logic [DATA_WIDTH-1:0] f_ext;
    logic [ADDR_WIDTH-1:0] rb_addr;
    logic                  is_mem_op;
    logic                  req_c;
    logic                  we_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    assign op        = ir_q[7:4];
    assign f         = ir_q[3:0];
    assign rb        = ir_q[RbW-1:0];
    assign rb_val    = regs_q[rb];
    assign f_ext     = DATA_WIDTH'(f);
    assign is_mem_op = (op == OpLd) || (op == OpSt);

    // Register value used as an address: zero-extend or truncate to the address width.
    generate
        if (ADDR_WIDTH > DATA_WIDTH) begin : g_addr_zext
            assign rb_addr = {{(ADDR_WIDTH - DATA_WIDTH){1'b0}}, rb_val};
        end else begin : g_addr_trunc
            assign rb_addr = rb_val[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        reg_we  = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = pc_q;

        case (state_q)
            StFetch: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[7:0];
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpAddi: acc_d = acc_q + f_ext;
                    OpAdd:  acc_d = acc_q + rb_val;
                    OpSub:  acc_d = acc_q - rb_val;
                    OpAnd:  acc_d = acc_q & rb_val;
                    OpOr:   acc_d = acc_q | rb_val;
                    OpXor:  acc_d = acc_q ^ rb_val;
                    OpMova: reg_we = 1'b1;
                    OpMovb: acc_d = rb_val;
                    OpLd:   state_d = StMem;
                    OpSt:   state_d = StMem;
                    OpBeqz: if (acc_q == '0) pc_d = rb_addr;
                    OpBnez: if (acc_q != '0) pc_d = rb_addr;
                    OpJmp:  pc_d = rb_addr;
                    OpShli: acc_d = (acc_q << 4) | f_ext;
                    OpHalt: state_d = StHalt;
                    default: ;
                endcase
            end
            StMem: begin
                req_c  = 1'b1;
                we_c   = (op == OpSt);
                addr_c = rb_addr;
                if (mem_ready) begin
                    if (op == OpLd) acc_d = mem_rdata;
                    state_d = StFetch;
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= ADDR_WIDTH'(RESET_PC);
            acc_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[rb] <= acc_q;
        end
    end

    // Reset masks the handshake so an in-flight transaction is dropped immediately.
    assign mem_req   = req_c & ~rst;
    assign mem_we    = we_c & ~rst;
    assign mem_addr  = addr_c;
    assign mem_wdata = acc_q;
    assign halted    = (state_q == StHalt) & ~rst;
    assign pc_out    = pc_q;
    assign acc_out   = acc_q;

`ifdef CPU_RETIRE_CNT_EN
    logic        retire;
    logic [15:0] retire_cnt_q;

    assign retire = ((state_q == StExec) && !is_mem_op) || ((state_q == StMem) && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire && (retire_cnt_q != 16'hFFFF)) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = rst ? 16'h0000 : retire_cnt_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_core_mc.sv
`timescale 1ns/1ps
// Bench for cpu_core_mc: instruction-level reference model predicts every memory transaction,
// a monitor pops and compares them as the core completes them under random ready stalls.
module tb_cpu_core_mc;

    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        halted;
    logic [7:0]  pc_out;
    logic [7:0]  acc_out;
    logic [15:0] retire_cnt;

    cpu_core_mc #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .NUM_REGS  (NR),
        .RESET_PC  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_out    (pc_out),
        .acc_out   (acc_out),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] bmem[256];
    logic [7:0] mdl_mem[256];
    int         n_checks = 0;
    int         n_fail = 0;
    int         ready_pct = 100;
    bit         block_writes = 1'b0;
    bit         open_ended = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input int a, input bit we, input int d);
        txn_t t;
        t.addr  = 8'(a);
        t.we    = we;
        t.wdata = 8'(d);
        return t;
    endfunction

    // Reference model: executes whole instructions with plain integer arithmetic.
    task automatic build_trace(input int max_insn, output bit m_halt, output int m_acc,
                               output int m_pc, output int m_ret);
        int r[NR];
        int pc, acc, insn, op, f, rb;
        for (int i = 0; i < NR; i++) r[i] = 0;
        pc = 0; acc = 0; m_halt = 0; m_ret = 0;
        for (int n = 0; n < max_insn; n++) begin
            insn = int'(mdl_mem[pc]);
            exp_q.push_back(mk(pc, 1'b0, 0));
            pc = (pc + 1) % 256;
            op = insn / 16; f = insn % 16; rb = f % NR;
            m_ret++;
            case (op)
                1:  acc = (acc + f) % 256;
                2:  acc = (acc + r[rb]) % 256;
                3:  acc = (acc - r[rb] + 256) % 256;
                4:  acc = acc & r[rb];
                5:  acc = acc | r[rb];
                6:  acc = acc ^ r[rb];
                7:  r[rb] = acc;
                8:  acc = r[rb];
                9:  begin
                    exp_q.push_back(mk(r[rb], 1'b0, 0));
                    acc = int'(mdl_mem[r[rb]]);
                end
                10: begin
                    exp_q.push_back(mk(r[rb], 1'b1, acc));
                    mdl_mem[r[rb]] = 8'(acc);
                end
                11: if (acc == 0) pc = r[rb];
                12: if (acc != 0) pc = r[rb];
                13: pc = r[rb];
                14: acc = (acc * 16 + f) % 256;
                15: m_halt = 1;
                default: ;
            endcase
            if (m_halt) break;
        end
        m_acc = acc;
        m_pc  = pc;
    endtask

    // Memory responder: random ready, read data from the bench memory.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = bmem[mem_addr];
            if (block_writes && mem_we) mem_ready = 1'b0;
            else mem_ready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    // Monitor: compares completed transactions and checks request stability while stalled.
    initial begin
        bit   prev_stall;
        txn_t prev_t;
        txn_t t;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {14'd0, mem_req, mem_we, mem_addr, mem_wdata},
                          {14'd0, 1'b1, prev_t.we, prev_t.addr, prev_t.wdata});
                if (mem_req && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        if (!open_ended) check("unexpected_txn", {23'd0, mem_we, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn_we", {31'd0, mem_we}, {31'd0, t.we});
                        check("txn_addr", {24'd0, mem_addr}, {24'd0, t.addr});
                        if (t.we) check("txn_wdata", {24'd0, mem_wdata}, {24'd0, t.wdata});
                    end
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    prev_stall = 1'b0;
                end else if (mem_req) begin
                    prev_stall = 1'b1;
                    prev_t = mk(int'(mem_addr), mem_we, int'(mem_wdata));
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic start_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retire", {16'd0, retire_cnt}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_pc", {24'd0, pc_out}, 32'd0);
        check("rst_acc", {24'd0, acc_out}, 32'd0);
    endtask

    // Expects rst already high and bmem loaded.
    task automatic run_program(input int max_insn, input int pct, output int halt_cyc);
        bit m_halt;
        int m_acc, m_pc, m_ret;
        bit done;
        exp_q.delete();
        ready_pct = pct;
        mdl_mem = bmem;
        build_trace(max_insn, m_halt, m_acc, m_pc, m_ret);
        open_ended = !m_halt;
        release_reset();
        done = 0;
        halt_cyc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && (!m_halt || halted)) begin
                done = 1;
                halt_cyc = i;
                break;
            end
        end
        check("run_done", {31'd0, done}, 32'd1);
        if (done && m_halt) begin
            check("end_halted", {31'd0, halted}, 32'd1);
            check("end_acc", {24'd0, acc_out}, m_acc);
            check("end_pc", {24'd0, pc_out}, m_pc);
`ifdef CPU_RETIRE_CNT_EN
            check("end_retire", {16'd0, retire_cnt}, m_ret);
`else
            check("end_retire", {16'd0, retire_cnt}, 32'd0);
`endif
            repeat (2) @(negedge clk);
            check("halt_no_req", {31'd0, mem_req}, 32'd0);
        end
    endtask

    task automatic load_prog(input logic [7:0] p[$]);
        for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
        for (int i = 0; i < p.size(); i++) bmem[i] = p[i];
    endtask

    initial begin
        int hc;
        logic [7:0] p[$];
        bit seen;

        // ADDI 3, SHLI 5, MOVA r0, HALT: halts 8 cycles after reset with ready high.
        start_reset();
        p = '{8'h13, 8'hE5, 8'h70, 8'hF0};
        load_prog(p);
        run_program(50, 100, hc);
        check("halt_cycles", hc, 32'd8);

        // Same program with stalls.
        start_reset();
        load_prog(p);
        run_program(50, 30, hc);

        // r1=0x20, LD r1 (0xAB), ADDI 1, ST r1.
        start_reset();
        p = '{8'h12, 8'hE0, 8'h71, 8'h91, 8'h11, 8'hA1, 8'hF0};
        load_prog(p);
        bmem[8'h20] = 8'hAB;
        run_program(50, 60, hc);
        check("st_result", {24'd0, bmem[8'h20]}, 32'hAC);

        // r2=0x40, taken BEQZ to 0x40, then not-taken BEQZ falls through to 0x42.
        start_reset();
        p = '{8'h14, 8'hE0, 8'h72, 8'h32, 8'hB2};
        load_prog(p);
        bmem[8'h40] = 8'h11;
        bmem[8'h41] = 8'hB2;
        bmem[8'h42] = 8'hF0;
        run_program(50, 70, hc);

        // Jump to 0xFF: ADDI 0xF wraps acc 0xFF->0x0E and the following fetch wraps to 0x00.
        start_reset();
        p = '{8'h1F, 8'hEF, 8'h71, 8'hD1, 8'hF0};
        load_prog(p);
        bmem[8'hFF] = 8'h1F;
        run_program(40, 80, hc);

        // Reset while a store is stalled in its memory phase.
        start_reset();
        p = '{8'h11, 8'h12, 8'hA0, 8'hF0};
        load_prog(p);
        exp_q.delete();
        open_ended = 1'b0;
        ready_pct = 100;
        block_writes = 1'b1;
        begin
            bit m_halt;
            int m_acc, m_pc, m_ret;
            mdl_mem = bmem;
            build_trace(3, m_halt, m_acc, m_pc, m_ret);
        end
        release_reset();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                seen = 1;
                break;
            end
        end
        check("st_reached", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        check("st_pending", exp_q.size(), 32'd1);
        check("st_addr_wait", {24'd0, mem_addr}, 32'd0);
        check("st_data_wait", {24'd0, mem_wdata}, 32'h03);
`ifdef CPU_RETIRE_CNT_EN
        check("pre_rst_retire", {16'd0, retire_cnt}, 32'd2);
`else
        check("pre_rst_retire", {16'd0, retire_cnt}, 32'd0);
`endif
        start_reset();
        block_writes = 1'b0;
        check("no_write_seen", {24'd0, bmem[0]}, 32'h11);
        run_program(100, 75, hc);

        // Random programs.
        for (int n = 0; n < 25; n++) begin
            start_reset();
            for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
            run_program(150, (n % 3 == 0) ? 100 : int'($urandom_range(40, 90)), hc);
        end

        start_reset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
